// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// the default instruction-memory word-address width.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 14;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream. word_valid_o fires
// combinationally alongside the transfer of the fourth byte.
module byte_to_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        xfer_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] lo_q, lo_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= 2'd0;
            lo_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            lo_q  <= lo_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        lo_d  = lo_q;
        if (clear_i) begin
            idx_d = 2'd0;
            lo_d  = 24'd0;
        end else if (xfer_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    lo_d[7:0]   = byte_i;
                2'd1:    lo_d[15:8]  = byte_i;
                2'd2:    lo_d[23:16] = byte_i;
                default: lo_d        = lo_q;
            endcase
        end
    end

    // The top byte is never stored: it is forwarded directly with the word.
    assign word_valid_o = xfer_i & (idx_q == 2'd3);
    assign word_o       = {byte_i, lo_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word image into instruction memory
// and holds the core in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W     = IMEM_ADDR_W,
    parameter int unsigned BASE_WADDR = 0,
    parameter int unsigned MAX_WORDS  = 16384
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_reset_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int                CNT_W  = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WADDR);
    localparam logic [31:0]       MAX_N  = 32'(MAX_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               xfer;
    logic               rearm;
    logic               pk_valid;
    logic [31:0]        pk_word;

    assign in_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
    assign xfer       = in_valid_i & in_ready_o;
    assign rearm      = start_i & ((state_q == S_DONE) || (state_q == S_ERR));

    byte_to_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (reset_i),
        .clear_i      (rearm),
        .xfer_i       (xfer),
        .byte_i       (in_data_i),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_LEN;
            len_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= BASE_A;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_LEN: begin
                if (pk_valid) begin
                    if (pk_word == 32'd0) begin
                        state_d = S_DONE;
                    end else if (pk_word > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = pk_word[CNT_W-1:0];
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pk_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = pk_word;
                    mem_waddr_d = BASE_A + ADDR_W'(cnt_q);
                    cnt_d       = cnt_q + CNT_W'(1);
                end
                // Leave only after the final write has been on the bus for a
                // cycle, so the core is released onto a complete image.
                if (mem_we_q && (cnt_q == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    len_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    assign mem_we_o     = mem_we_q;
    assign mem_waddr_o  = mem_waddr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign core_reset_o = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0 and base 0x3FFF)
// share one byte stream and are compared against an image-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready_a, mem_we_a, core_reset_a, done_a, err_a;
    logic [13:0] mem_waddr_a;
    logic [31:0] mem_wdata_a;
    logic        in_ready_b, mem_we_b, core_reset_b, done_b, err_b;
    logic [13:0] mem_waddr_b;
    logic [31:0] mem_wdata_b;

    imem_loader #(.ADDR_W(14), .BASE_WADDR(0), .MAX_WORDS(16384)) dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_a),
        .mem_we_o(mem_we_a), .mem_waddr_o(mem_waddr_a), .mem_wdata_o(mem_wdata_a),
        .core_reset_o(core_reset_a), .done_o(done_a), .err_o(err_a)
    );

    imem_loader #(.ADDR_W(14), .BASE_WADDR(16383), .MAX_WORDS(16384)) dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_b),
        .mem_we_o(mem_we_b), .mem_waddr_o(mem_waddr_b), .mem_wdata_o(mem_wdata_b),
        .core_reset_o(core_reset_b), .done_o(done_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Observed traffic of the current scenario.
    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [13:0] wr_addr_b[$];
    logic [31:0] wr_data_b[$];
    logic        wr_crst[$];
    int          done_rise = -1;
    logic        done_prev = 1'b0;
    int          stalls = 0;
    logic [31:0] fixed_words[$];

    always @(negedge clk) begin
        if (in_valid && in_ready_a) acc_cyc.push_back(cyc);
        if (mem_we_a) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_waddr_a);
            wr_data.push_back(mem_wdata_a);
            wr_crst.push_back(core_reset_a);
        end
        if (mem_we_b) begin
            wr_addr_b.push_back(mem_waddr_b);
            wr_data_b.push_back(mem_wdata_b);
        end
        if (done_a && !done_prev) done_rise = cyc;
        done_prev = done_a;
    end

    task automatic clear_mon();
        acc_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_addr_b.delete();
        wr_data_b.delete();
        wr_crst.delete();
        done_rise = -1;
        stalls    = 0;
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        @(negedge clk);
        if (!in_ready_a) stalls++;
        while (!in_ready_a && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_a) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rearm();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rearm_done", 32'(done_a), 32'd0);
        chk("rearm_err", 32'(err_a), 32'd0);
        chk("rearm_core_reset", 32'(core_reset_a), 32'd1);
        chk("rearm_in_ready", 32'(in_ready_a), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input logic [31:0] n, input int max_gap, input bit start_mid);
        logic [7:0]  bytes[$];
        logic [31:0] words[$];
        logic [31:0] w;
        int          gap;
        int          last;
        bit          ok_len;
        clear_mon();
        ok_len = (n != 32'd0) && (n <= 32'd16384);
        for (int i = 0; i < 4; i++) bytes.push_back(8'(n >> (8 * i)));
        if (ok_len) begin
            for (int k = 0; k < int'(n); k++) begin
                w = (k < fixed_words.size()) ? fixed_words[k] : $urandom;
                words.push_back(w);
                for (int i = 0; i < 4; i++) bytes.push_back(8'(w >> (8 * i)));
            end
        end
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            if (start_mid && i == 5) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(bytes[i], gap);
        end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        last = bytes.size() - 1;
        chk("acc_count", 32'(acc_cyc.size()), 32'(bytes.size()));
        chk("stalls", 32'(stalls), 32'd0);
        if (n > 32'd16384) begin
            chk("err_a", 32'(err_a), 32'd1);
            chk("err_b", 32'(err_b), 32'd1);
            chk("err_core_reset", 32'(core_reset_a), 32'd1);
            chk("err_in_ready", 32'(in_ready_a), 32'd0);
            chk("err_done", 32'(done_a), 32'd0);
            chk("err_writes", 32'(wr_cyc.size()), 32'd0);
        end else begin
            chk("wr_count_a", 32'(wr_cyc.size()), n);
            chk("wr_count_b", 32'(wr_addr_b.size()), n);
            for (int k = 0; k < words.size(); k++) begin
                if (k < wr_cyc.size()) begin
                    chk("wdata_a", wr_data[k], words[k]);
                    chk("waddr_a", 32'(wr_addr[k]), 32'(k % 16384));
                    chk("wr_core_reset", 32'(wr_crst[k]), 32'd1);
                    if (acc_cyc.size() == bytes.size())
                        chk("wr_latency", 32'(wr_cyc[k]), 32'(acc_cyc[4 * k + 7] + 1));
                end
                if (k < wr_addr_b.size()) begin
                    chk("wdata_b", wr_data_b[k], words[k]);
                    chk("waddr_b", 32'(wr_addr_b[k]), 32'((16383 + k) % 16384));
                end
            end
            if (acc_cyc.size() == bytes.size())
                chk("done_rise", 32'(done_rise), 32'(acc_cyc[last] + ((n == 32'd0) ? 1 : 2)));
            chk("done_a", 32'(done_a), 32'd1);
            chk("done_b", 32'(done_b), 32'd1);
            chk("done_core_reset_a", 32'(core_reset_a), 32'd0);
            chk("done_core_reset_b", 32'(core_reset_b), 32'd0);
            chk("done_in_ready", 32'(in_ready_a), 32'd0);
            chk("done_err", 32'(err_a), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #2;
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        chk("rst_mem_we", 32'(mem_we_a), 32'd0);
        chk("rst_waddr_a", 32'(mem_waddr_a), 32'd0);
        chk("rst_waddr_b", 32'(mem_waddr_b), 32'h3FFF);
        chk("rst_wdata", mem_wdata_a, 32'd0);
        chk("rst_core_reset", 32'(core_reset_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed two-word image, back-to-back bytes.
        fixed_words = '{32'h0000_0013, 32'h0010_0093};
        run_load(32'd2, 0, 1'b0);

        rearm();
        run_load(32'd0, 0, 1'b0);

        rearm();
        run_load(32'd16385, 0, 1'b0);
        rearm();

        // Same image with random idle cycles between bytes.
        run_load(32'd2, 5, 1'b0);
        fixed_words.delete();

        // Reset after 6 of 8 payload bytes.
        rearm();
        clear_mon();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_core_reset", 32'(core_reset_a), 32'd1);
        chk("rstmid_done", 32'(done_a), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we_a), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("rstmid_writes", 32'(wr_cyc.size()), 32'd1);
        chk("rstmid_in_ready", 32'(in_ready_a), 32'd1);
        run_load(32'd1, 2, 1'b0);

        // Bytes offered after completion must be refused.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            chk("post_done_in_ready", 32'(in_ready_a), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("post_done_acc", 32'(acc_cyc.size()), 32'd0);
        chk("post_done_writes", 32'(wr_cyc.size()), 32'd0);
        rearm();
        run_load(32'd1, 2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rearm();
            run_load(32'($urandom_range(8, 1)), 5, 1'($urandom_range(1, 0)));
        end

        rearm();
        run_load(32'hFFFF_FFFF, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
